// File: rtl/ct_spsram_128x104_arb.sv
// Two-port round-robin arbiter/sequencer for a 128x104 single-port SRAM with 4 write lanes.
// Define CT_SPSRAM_ARB_INIT_EN to clear the whole array to zero after every reset.
module ct_spsram_128x104_arb #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 104,
    parameter int LANE_NUM   = 4,
    parameter int LANE_WIDTH = 26
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req0_vld,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [LANE_NUM-1:0]   req0_wmask,
    output logic                  req0_rdy,
    input  logic                  req1_vld,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [LANE_NUM-1:0]   req1_wmask,
    output logic                  req1_rdy,
    output logic                  rsp0_vld,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_vld,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  init_busy,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    logic                  run;
    logic                  init_wr;
    logic [ADDR_WIDTH-1:0] init_cnt;

`ifdef CT_SPSRAM_ARB_INIT_EN
    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = 1;

    logic state;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + CNT_ONE;
            if (&init_cnt)
                state <= ST_RUN;
        end
    end

    assign init_wr = cpurst_b & (state == ST_INIT);
    assign run     = cpurst_b & (state == ST_RUN);
`else
    assign init_cnt = '0;
    assign init_wr  = 1'b0;
    assign run      = cpurst_b;
`endif

    assign init_busy = init_wr;

    logic rr_ptr;
    logic vld0, vld1, gnt0, gnt1;

    // rr_ptr names the winner of the next conflict; it only moves when both contend.
    assign vld0 = req0_vld & run;
    assign vld1 = req1_vld & run;
    assign gnt0 = vld0 & (~vld1 | ~rr_ptr);
    assign gnt1 = vld1 & (~vld0 | rr_ptr);
    assign req0_rdy = gnt0;
    assign req1_rdy = gnt1;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b)
            rr_ptr <= 1'b0;
        else if (vld0 & vld1)
            rr_ptr <= ~rr_ptr;
    end

    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [LANE_NUM-1:0]   sel_mask;
    logic [ADDR_WIDTH-1:0] a_hold;
    logic [DATA_WIDTH-1:0] d_hold;

    assign sel_wr    = gnt1 ? req1_wr    : req0_wr;
    assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
    assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;
    assign sel_mask  = gnt1 ? req1_wmask : req0_wmask;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = a_hold;
        sram_d    = d_hold;
        if (!cpurst_b) begin
            sram_a = '0;
            sram_d = '0;
        end else if (init_wr) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_cnt;
            sram_d    = '0;
        end else if (gnt0 | gnt1) begin
            sram_cen  = 1'b0;
            sram_gwen = ~(sel_wr & (|sel_mask));
            for (int k = 0; k < LANE_NUM; k++)
                sram_wen[k*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{~sel_mask[k]}};
            sram_a    = sel_addr;
            sram_d    = sel_wdata;
        end
    end

    // Address/data pins keep the last driven value while the SRAM is idle.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            a_hold <= '0;
            d_hold <= '0;
        end else if (!sram_cen) begin
            a_hold <= sram_a;
            d_hold <= sram_d;
        end
    end

    logic                  rd_pend0, rd_pend1;
    logic [DATA_WIDTH-1:0] rsp0_hold, rsp1_hold;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            rd_pend0  <= 1'b0;
            rd_pend1  <= 1'b0;
            rsp0_hold <= '0;
            rsp1_hold <= '0;
        end else begin
            rd_pend0 <= gnt0 & ~req0_wr;
            rd_pend1 <= gnt1 & ~req1_wr;
            if (rd_pend0)
                rsp0_hold <= sram_q;
            if (rd_pend1)
                rsp1_hold <= sram_q;
        end
    end

    // Read data passes straight from the SRAM in the response cycle; a reset then drops it.
    assign rsp0_vld   = rd_pend0 & cpurst_b;
    assign rsp1_vld   = rd_pend1 & cpurst_b;
    assign rsp0_rdata = !cpurst_b ? '0 : (rd_pend0 ? sram_q : rsp0_hold);
    assign rsp1_rdata = !cpurst_b ? '0 : (rd_pend1 ? sram_q : rsp1_hold);

endmodule

// File: tb/tb_ct_spsram_128x104_arb.sv
// Self-checking bench for ct_spsram_128x104_arb: SRAM model, table vectors, random traffic.
// Works with or without CT_SPSRAM_ARB_INIT_EN defined.
module tb_ct_spsram_128x104_arb;

    localparam int AW = 7;
    localparam int DW = 104;
    localparam int LN = 4;
    localparam int LW = 26;

    typedef struct {
        logic          v0;
        logic          w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [LN-1:0] m0;
        logic          v1;
        logic          w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [LN-1:0] m1;
        logic          eg0;
        logic          eg1;
        logic          egwen;
    } vec_t;

    logic          clk = 1'b0;
    logic          cpurst_b;
    logic          req0_vld, req0_wr, req0_rdy;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic [LN-1:0] req0_wmask;
    logic          req1_vld, req1_wr, req1_rdy;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [LN-1:0] req1_wmask;
    logic          rsp0_vld, rsp1_vld, init_busy;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_q = '0;
    logic [DW-1:0] sram_mem [128] = '{default: '0};

    always #5 clk = ~clk;

    ct_spsram_128x104_arb dut (
        .forever_cpuclk(clk),
        .cpurst_b(cpurst_b),
        .req0_vld(req0_vld),
        .req0_wr(req0_wr),
        .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),
        .req0_wmask(req0_wmask),
        .req0_rdy(req0_rdy),
        .req1_vld(req1_vld),
        .req1_wr(req1_wr),
        .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),
        .req1_wmask(req1_wmask),
        .req1_rdy(req1_rdy),
        .rsp0_vld(rsp0_vld),
        .rsp0_rdata(rsp0_rdata),
        .rsp1_vld(rsp1_vld),
        .rsp1_rdata(rsp1_rdata),
        .init_busy(init_busy),
        .sram_cen(sram_cen),
        .sram_gwen(sram_gwen),
        .sram_wen(sram_wen),
        .sram_a(sram_a),
        .sram_d(sram_d),
        .sram_q(sram_q)
    );

    // Behavioural single-port SRAM: bit-masked write, registered read.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    logic [DW-1:0] ref_mem [128] = '{default: '0};
    int            init_left = 0;
    logic          pri = 1'b0;
    logic          pend0 = 1'b0, pend1 = 1'b0;
    logic [DW-1:0] pend_d0 = '0, pend_d1 = '0, hold0 = '0, hold1 = '0;
    logic [AW-1:0] last_a = '0;
    logic [DW-1:0] last_d = '0;
    int            n_cmp = 0;
    int            n_fail = 0;

    function automatic logic [DW-1:0] lane_bits(input logic [LN-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < LN; k++)
            for (int j = 0; j < LW; j++)
                r[k*LW+j] = m[k];
        return r;
    endfunction

    function automatic vec_t mk(input logic v0, input logic w0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic [LN-1:0] m0,
                                input logic v1, input logic w1, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d1, input logic [LN-1:0] m1,
                                input logic eg0, input logic eg1, input logic egwen);
        vec_t v;
        v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.m0 = m0;
        v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.m1 = m1;
        v.eg0 = eg0; v.eg1 = eg1; v.egwen = egwen;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, check every output at the falling edge, then advance the model.
    task automatic apply_stimulus(input logic rst_n, input vec_t v,
                                  output logic ag0, output logic ag1, output logic agwen);
        logic          e_init, e_run, e_g0, e_g1, g_any, g_wr;
        logic [AW-1:0] g_a, e_a;
        logic [DW-1:0] g_d, e_d, e_wen;
        logic [LN-1:0] g_m;
        logic          e_cen, e_gwen;
        cpurst_b   = rst_n;
        req0_vld   = v.v0; req0_wr = v.w0; req0_addr = v.a0; req0_wdata = v.d0; req0_wmask = v.m0;
        req1_vld   = v.v1; req1_wr = v.w1; req1_addr = v.a1; req1_wdata = v.d1; req1_wmask = v.m1;
        @(negedge clk);
        e_init = rst_n && (init_left > 0);
        e_run  = rst_n && (init_left == 0);
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (e_run) begin
            if (v.v0 && v.v1) begin
                e_g0 = (pri == 1'b0);
                e_g1 = (pri == 1'b1);
            end else begin
                e_g0 = v.v0;
                e_g1 = v.v1;
            end
        end
        g_any = e_g0 || e_g1;
        g_wr = e_g0 ? v.w0 : v.w1;
        g_a  = e_g0 ? v.a0 : v.a1;
        g_d  = e_g0 ? v.d0 : v.d1;
        g_m  = e_g0 ? v.m0 : v.m1;
        e_cen = 1'b1; e_gwen = 1'b1; e_wen = '1; e_a = last_a; e_d = last_d;
        if (!rst_n) begin
            e_a = '0;
            e_d = '0;
        end else if (e_init) begin
            e_cen = 1'b0; e_gwen = 1'b0; e_wen = '0;
            e_a = AW'(128 - init_left);
            e_d = '0;
        end else if (g_any) begin
            e_cen  = 1'b0;
            e_gwen = !(g_wr && (g_m != 0));
            e_wen  = ~lane_bits(g_m);
            e_a    = g_a;
            e_d    = g_d;
        end
        check_output("rdy0", req0_rdy, e_g0);
        check_output("rdy1", req1_rdy, e_g1);
        check_output("init_busy", init_busy, e_init);
        check_output("sram_cen", sram_cen, e_cen);
        check_output("sram_gwen", sram_gwen, e_gwen);
        check_output("sram_wen", sram_wen, e_wen);
        check_output("sram_a", sram_a, e_a);
        check_output("sram_d", sram_d, e_d);
        check_output("rsp0_vld", rsp0_vld, rst_n && pend0);
        check_output("rsp1_vld", rsp1_vld, rst_n && pend1);
        check_output("rsp0_rdata", rsp0_rdata, !rst_n ? '0 : (pend0 ? pend_d0 : hold0));
        check_output("rsp1_rdata", rsp1_rdata, !rst_n ? '0 : (pend1 ? pend_d1 : hold1));
        ag0 = req0_rdy;
        ag1 = req1_rdy;
        agwen = sram_gwen;
        @(posedge clk);
        if (!rst_n) begin
            pri = 1'b0; pend0 = 1'b0; pend1 = 1'b0; hold0 = '0; hold1 = '0;
            last_a = '0; last_d = '0;
`ifdef CT_SPSRAM_ARB_INIT_EN
            init_left = 128;
            for (int i = 0; i < 128; i++)
                ref_mem[i] = '0;
`else
            init_left = 0;
`endif
        end else begin
            if (pend0) hold0 = pend_d0;
            if (pend1) hold1 = pend_d1;
            pend0 = 1'b0;
            pend1 = 1'b0;
            if (e_init) begin
                last_a = e_a;
                last_d = '0;
                init_left--;
            end else if (g_any) begin
                last_a = g_a;
                last_d = g_d;
                if (g_wr) begin
                    if (g_m != 0)
                        ref_mem[g_a] = (ref_mem[g_a] & ~lane_bits(g_m)) | (g_d & lane_bits(g_m));
                end else if (e_g0) begin
                    pend0 = 1'b1;
                    pend_d0 = ref_mem[g_a];
                end else begin
                    pend1 = 1'b1;
                    pend_d1 = ref_mem[g_a];
                end
            end
            if (e_run && v.v0 && v.v1)
                pri = ~pri;
        end
        #1;
    endtask

    localparam logic [DW-1:0] ALL1   = {DW{1'b1}};
    localparam logic [DW-1:0] DATA_A = {4{26'h2ABCDEF}};
    localparam logic [DW-1:0] LANE02 = {26'h0, 26'h3FFFFFF, 26'h0, 26'h3FFFFFF};

    initial begin
        vec_t tbl[$];
        vec_t idle, busy, rv;
        logic ag0, ag1, agwen;

        idle = mk(0, 0, 7'h00, '0, 4'h0, 0, 0, 7'h00, '0, 4'h0, 0, 0, 1);
        busy = mk(1, 0, 7'h05, '0, 4'hF, 1, 1, 7'h06, ALL1, 4'hF, 0, 0, 1);

        tbl.push_back(mk(1, 0, 7'h00, '0,     4'h0, 0, 0, 7'h00, '0, 4'h0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 7'h7F, '0,     4'h0, 0, 0, 7'h00, '0, 4'h0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 7'h05, ALL1,   4'h5, 0, 0, 7'h00, '0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 7'h05, '0,     4'h0, 0, 0, 7'h00, '0, 4'h0, 1, 0, 1));
        tbl.push_back(idle);
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1, 0, 7'h05, '0, 4'h0, 1, 0, 7'h7F, '0, 4'h0,
                             (i % 2) == 0, (i % 2) == 1, 1));
        tbl.push_back(mk(0, 0, 7'h00, '0,     4'h0, 1, 1, 7'h10, DATA_A, 4'hF, 0, 1, 0));
        tbl.push_back(mk(1, 0, 7'h10, '0,     4'h0, 0, 0, 7'h00, '0, 4'h0, 1, 0, 1));
        tbl.push_back(idle);
        tbl.push_back(mk(1, 1, 7'h05, DATA_A, 4'h0, 0, 0, 7'h00, '0, 4'h0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 7'h05, '0,     4'h0, 0, 0, 7'h00, '0, 4'h0, 1, 0, 1));
        tbl.push_back(idle);

        cpurst_b = 1'b0;
        req0_vld = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
        req1_vld = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
        @(posedge clk);
        #1;

        $display("[TB] reset with requests pending");
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b0, busy, ag0, ag1, agwen);

        $display("[TB] post-reset clear phase");
        for (int i = 0; i < 130; i++)
            if (init_left > 0)
                apply_stimulus(1'b1, busy, ag0, ag1, agwen);

        $display("[TB] directed vector table");
        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(1'b1, tbl[i], ag0, ag1, agwen);
            check_output($sformatf("tbl%0d_rdy0", i), ag0, tbl[i].eg0);
            check_output($sformatf("tbl%0d_rdy1", i), ag1, tbl[i].eg1);
            check_output($sformatf("tbl%0d_gwen", i), agwen, tbl[i].egwen);
            if (i == 4 || i == 16)
                check_output($sformatf("tbl%0d_lane_data", i), rsp0_rdata, LANE02);
            if (i == 13)
                check_output("raw_data", rsp0_rdata, DATA_A);
        end

        $display("[TB] reset while a read is in flight");
        apply_stimulus(1'b1, mk(1, 0, 7'h05, '0, 4'h0, 0, 0, 7'h00, '0, 4'h0, 1, 0, 1), ag0, ag1, agwen);
        apply_stimulus(1'b0, idle, ag0, ag1, agwen);
        apply_stimulus(1'b0, idle, ag0, ag1, agwen);
        for (int i = 0; i < 130; i++)
            if (init_left > 0)
                apply_stimulus(1'b1, busy, ag0, ag1, agwen);
        apply_stimulus(1'b1, mk(0, 0, 7'h00, '0, 4'h0, 1, 0, 7'h05, '0, 4'h0, 0, 1, 1), ag0, ag1, agwen);
        apply_stimulus(1'b1, idle, ag0, ag1, agwen);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rv = idle;
            rv.v0 = 1'($urandom_range(0, 1));
            rv.w0 = 1'($urandom_range(0, 1));
            rv.a0 = AW'($urandom_range(0, 7));
            rv.d0 = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
            rv.m0 = LN'($urandom());
            rv.v1 = 1'($urandom_range(0, 1));
            rv.w1 = 1'($urandom_range(0, 1));
            rv.a1 = AW'($urandom_range(0, 7));
            rv.d1 = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
            rv.m1 = LN'($urandom());
            apply_stimulus(1'b1, rv, ag0, ag1, agwen);
        end
        apply_stimulus(1'b1, idle, ag0, ag1, agwen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
